// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported instruction/data memory between the
//            instruction-fetch path (if_*) and the load/store path (dm_*).
//            Latches the winning request and drives the memory until
//            mem_ready or a watchdog timeout. Then returns the read data to
//            the owner with a one-cycle valid pulse.
// Ports    : clk, rst (async, active-high)
//            if_req/if_addr -> if_gnt/if_valid/if_rdata      fetch side
//            dm_req/we/be/addr/wdata -> dm_gnt/valid/rdata   load/store side
//            err                                             timeout flag on valid
//            mem_req/we/be/addr/wdata, mem_ready/mem_rdata   memory side
//            busy                                            state != IDLE
// Config   : MEM_ARB_RR_EN  defined   -> round-robin on a tie
//                           undefined -> dm always wins a tie
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DW-1:0]     if_rdata,
    // load/store
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [DW/8-1:0]   dm_be,
    input  logic [AW-1:0]     dm_addr,
    input  logic [DW-1:0]     dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DW-1:0]     dm_rdata,
    output logic              err,
    // memory
    output logic              mem_req,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_be,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ready,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);

    localparam int c_CNT_W = $clog2(TO_CYC + 1);
    // Timeout fires in the ACCESS cycle whose increment would reach TO_CYC,
    // so the valid pulse lands TO_CYC cycles after the grant.
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TO_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TO_CYC);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_owner_dm;   // 1 = load/store owns the access
    logic               w_any_req;
    logic               w_pick_dm;
    logic               w_timeout;
    logic [DW-1:0]      w_cap_data;

`ifdef MEM_ARB_RR_EN
    logic               r_last_dm;    // owner of the previous grant, 0 = fetch
    // On a tie the requester that did not own the previous access wins.
    assign w_pick_dm = dm_req & (~if_req | ~r_last_dm);
`else
    // Fixed priority: load/store always wins a tie.
    assign w_pick_dm = dm_req;
`endif

    assign w_any_req  = if_req | dm_req;
    assign w_timeout  = ~mem_ready & (r_cnt == c_TO_LAST);
    // Stores and timeouts return zero; loads and fetches return memory data.
    assign w_cap_data = (mem_ready && !mem_we) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_owner_dm <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_dm  <= 1'b0;
`endif
            if_gnt     <= 1'b0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            dm_gnt     <= 1'b0;
            dm_valid   <= 1'b0;
            dm_rdata   <= '0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            // Pulses default low; each is set for exactly one cycle below.
            if_gnt   <= 1'b0;
            dm_gnt   <= 1'b0;
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            err      <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner_dm <= w_pick_dm;
`ifdef MEM_ARB_RR_EN
                        r_last_dm  <= w_pick_dm;
`endif
                        if (w_pick_dm) begin
                            mem_we    <= dm_we;
                            mem_be    <= dm_be;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            dm_gnt    <= 1'b1;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_be    <= '1;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            if_gnt    <= 1'b1;
                        end
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= c_ACCESS;
                    end
                end

                c_ACCESS: begin
                    if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (mem_ready || w_timeout) begin
                        // Valid/rdata/err are registered here so they appear
                        // during the single DONE cycle.
                        if (r_owner_dm) begin
                            dm_valid <= 1'b1;
                            dm_rdata <= w_cap_data;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= w_cap_data;
                        end
                        err     <= w_timeout;
                        mem_req <= 1'b0;
                        r_state <= c_DONE;
                    end
                end

                c_DONE: begin
                    if_rdata <= '0;
                    dm_rdata <= '0;
                    r_cnt    <= '0;
                    busy     <= 1'b0;
                    r_state  <= c_IDLE;
                end

                default: begin
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
